// File: rtl/count_sequence_monitor.sv
// count_sequence_monitor
//
// Watches the 4-bit count produced by a ripple counter and checks that every
// sample is the previous sample plus one (mod 16). After LOCK_N consecutive
// good steps the monitor locks. While locked it counts 15->0 wraps and step
// errors. Each new wrap count is offered to a reader over a valid/ready port.
//
// Ports
//   clock         in   rising-edge clock
//   reset         in   asynchronous, active-low; clears all state
//   bit_1..bit_4  in   counter value, bit_1 is the LSB
//   clear         in   synchronous clear of statistics and report port
//   locked        out  monitor is in the LOCKED state
//   wrap_pulse    out  one-cycle strobe per wrap seen while locked
//   wrap_count    out  wraps seen while locked, modulo 2^WRAP_W
//   err_count     out  step errors seen while locked, saturating
//   error         out  sticky step-error flag
//   report_valid  out  report_data holds unread data
//   report_ready  in   reader accepts the report
//   report_data   out  wrap_count snapshot taken at the last wrap
//   report_lost   out  sticky; an unread report was overwritten
module count_sequence_monitor #(
    parameter int WRAP_W = 8,
    parameter int ERR_W  = 4,
    parameter int LOCK_N = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              bit_1,
    input  logic              bit_2,
    input  logic              bit_3,
    input  logic              bit_4,
    input  logic              clear,
    output logic              locked,
    output logic              wrap_pulse,
    output logic [WRAP_W-1:0] wrap_count,
    output logic [ERR_W-1:0]  err_count,
    output logic              error,
    output logic              report_valid,
    input  logic              report_ready,
    output logic [WRAP_W-1:0] report_data,
    output logic              report_lost
);

    localparam logic [1:0] S_EMPTY   = 2'd0;
    localparam logic [1:0] S_ACQUIRE = 2'd1;
    localparam logic [1:0] S_LOCKED  = 2'd2;

    // good_run value at which the next good step completes acquisition
    localparam logic [3:0] LOCK_LAST = 4'(LOCK_N - 1);

    localparam logic [WRAP_W-1:0] WRAP_ONE = {{(WRAP_W-1){1'b0}}, 1'b1};
    localparam logic [ERR_W-1:0]  ERR_ONE  = {{(ERR_W-1){1'b0}}, 1'b1};

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        return (&v) ? v : (v + ERR_ONE);
    endfunction

    logic [1:0]        r_state;
    logic [3:0]        r_prev;
    logic [3:0]        r_good_run;
    logic              r_wrap_pulse;
    logic [WRAP_W-1:0] r_wrap_count;
    logic [ERR_W-1:0]  r_err_count;
    logic              r_error;
    logic              r_report_valid;
    logic [WRAP_W-1:0] r_report_data;
    logic              r_report_lost;

    logic [3:0]        w_cur;
    logic [3:0]        w_prev_inc;
    logic              w_good;
    logic              w_wrap;
    logic              w_step_err;
    logic [WRAP_W-1:0] w_wrap_next;

    assign w_cur       = {bit_4, bit_3, bit_2, bit_1};
    assign w_prev_inc  = r_prev + 4'd1;
    assign w_good      = (w_cur == w_prev_inc);
    // a good step out of 15 can only land on 0, so this is the 15->0 wrap
    assign w_wrap      = (r_state == S_LOCKED) && w_good && (r_prev == 4'hF);
    assign w_step_err  = (r_state == S_LOCKED) && !w_good;
    assign w_wrap_next = r_wrap_count + WRAP_ONE;

    // Sequence tracking FSM; clear never touches it
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= S_EMPTY;
            r_prev     <= 4'd0;
            r_good_run <= 4'd0;
        end else begin
            r_prev <= w_cur;
            case (r_state)
                S_EMPTY: begin
                    // first sample only seeds prev; nothing to compare against
                    r_state    <= S_ACQUIRE;
                    r_good_run <= 4'd0;
                end
                S_ACQUIRE: begin
                    if (w_good) begin
                        if (r_good_run == LOCK_LAST) begin
                            r_state    <= S_LOCKED;
                            r_good_run <= 4'd0;
                        end else begin
                            r_good_run <= r_good_run + 4'd1;
                        end
                    end else begin
                        r_good_run <= 4'd0;
                    end
                end
                S_LOCKED: begin
                    if (!w_good) begin
                        r_state    <= S_ACQUIRE;
                        r_good_run <= 4'd0;
                    end
                end
                default: begin
                    r_state    <= S_EMPTY;
                    r_good_run <= 4'd0;
                end
            endcase
        end
    end

    // Statistics and report port; clear beats any same-edge wrap or error
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wrap_pulse   <= 1'b0;
            r_wrap_count   <= '0;
            r_err_count    <= '0;
            r_error        <= 1'b0;
            r_report_valid <= 1'b0;
            r_report_data  <= '0;
            r_report_lost  <= 1'b0;
        end else if (clear) begin
            r_wrap_pulse   <= 1'b0;
            r_wrap_count   <= '0;
            r_err_count    <= '0;
            r_error        <= 1'b0;
            r_report_valid <= 1'b0;
            r_report_data  <= '0;
            r_report_lost  <= 1'b0;
        end else begin
            r_wrap_pulse <= w_wrap;
            if (w_step_err) begin
                r_err_count <= sat_inc(r_err_count);
                r_error     <= 1'b1;
            end
            if (w_wrap) begin
                r_wrap_count   <= w_wrap_next;
                r_report_data  <= w_wrap_next;
                r_report_valid <= 1'b1;
                // unread data is being replaced; a same-edge read is not a loss
                if (r_report_valid && !report_ready) begin
                    r_report_lost <= 1'b1;
                end
            end else if (report_ready) begin
                r_report_valid <= 1'b0;
            end
        end
    end

    assign locked       = (r_state == S_LOCKED);
    assign wrap_pulse   = r_wrap_pulse;
    assign wrap_count   = r_wrap_count;
    assign err_count    = r_err_count;
    assign error        = r_error;
    assign report_valid = r_report_valid;
    assign report_data  = r_report_data;
    assign report_lost  = r_report_lost;

endmodule
